uart_cmd_framer: RTL and testbench
==================================

# uart_cmd_framer

Parametrised command framer between the UART byte receiver and the command processor. It consumes received bytes through a ready/clear handshake and assembles `BYTES` consecutive bytes, first byte most significant, into one command word. Completed commands are queued in a `DEPTH`-entry FIFO for the consumer. A partial command is discarded if the next byte does not arrive within `TIMEOUT` cycles, which resynchronises framing after line noise or a dropped byte.

## Interface
- `BYTES`, 2: bytes per command, 1..8; command width `W = 8*BYTES`.
- `DEPTH`, 4: command FIFO entries, power of two, 2..16.
- `TIMEOUT`, 0: maximum number of idle cycles between bytes of one command; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_rdy`  in  1  receiver holds a byte; stays high until cleared.
- `rx_data`  in  8  received byte; valid while `rx_rdy` is high.
- `rx_clr_rdy`  out  1  combinational; consumes the current byte.
- `clr_cmd_rdy`  in  1  consumer pops the FIFO head.
- `cmd_rdy`  out  1  FIFO not empty.
- `cmd`  out  W  FIFO head; undefined while `cmd_rdy` is low.
- `cmd_cnt`  out  clog2(DEPTH)+1  number of queued commands.
- `overflow`  out  1  sticky; a completed command was dropped.
- `timeout_err`  out  1  one-cycle pulse; a partial command was discarded.

## Operation
- State machine with two states:
  - IDLE: no bytes held.
  - COLLECT: 1..BYTES-1 bytes held.
- Byte counter `bcnt`, range 0..BYTES-1.
- Byte acceptance:
  - `rx_clr_rdy = rx_rdy & ~rst`, so every byte is consumed in the cycle it is seen, in either state.
  - Accepted byte shifts into the low end of the assembly register; `bcnt` increments.
- Command completion:
  - When an accepted byte has `bcnt == BYTES-1`, the word `{held bytes, rx_data}` is pushed to the FIFO.
  - `bcnt` returns to 0 and the state returns to IDLE.
  - With `BYTES==1`, every byte pushes immediately and COLLECT is never entered.
- Idle counter:
  - Cleared on every accepted byte.
  - Increments each cycle in COLLECT without a byte, saturating at `TIMEOUT`.
  - If `TIMEOUT>0` and the idle counter reaches `TIMEOUT` with no byte in that cycle: discard the held bytes, set `bcnt` to 0, go to IDLE, and pulse `timeout_err` for that cycle.
  - A byte arriving in the same cycle the counter reaches `TIMEOUT` wins: it is accepted and no timeout occurs.
- FIFO:
  - Circular buffer with read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
  - `cmd_cnt` is 0..DEPTH.
  - Pop when `clr_cmd_rdy` is high and `cmd_cnt>0`; a pop on an empty FIFO is ignored.
  - Push when full with no pop in the same cycle: the command is dropped, `overflow` is set and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both succeed and `cmd_cnt` stays at DEPTH.
  - Push and pop in the same cycle while empty: the push completes, the pop is ignored and `cmd_cnt` becomes 1.
- `overflow` is cleared only by `rst`.
- Reset (`rst` high at a clock edge) applies from any state, including mid-command:
  - state IDLE, `bcnt` 0, idle counter 0, pointers 0;
  - `cmd_rdy` 0, `cmd_cnt` 0, `overflow` 0, `timeout_err` 0;
  - `rx_clr_rdy` forced 0 while `rst` is high;
  - held bytes are lost and queued commands are flushed.

## Timing
- A byte presented at cycle T is accepted in cycle T, with `rx_clr_rdy` high during T.
  - The receiver drops `rx_rdy` by T+1, so one byte is accepted at most once.
- Final byte accepted at T:
  - `cmd_rdy` is high and `cmd` is valid from T+1.
  - This is a one-cycle latency when the FIFO was empty.
- Pop at T: `cmd` shows the next entry, or `cmd_rdy` falls, from T+1.
- Back-to-back bytes in consecutive cycles are supported at full rate.
- Timeout:
  - Last byte at T, no further byte: the idle counter reaches `TIMEOUT` at cycle T+TIMEOUT.
  - `timeout_err` is high in cycle T+TIMEOUT+1, and the state is IDLE from T+TIMEOUT+1.
  - A byte at T+TIMEOUT is still part of the current command.
- `timeout_err` is never high for two consecutive cycles.

## Test plan
- Defaults: bytes 0xA5 then 0x3C with `rx_rdy` pulsed -> `cmd=0xA53C`, `cmd_rdy` high the cycle after the second byte, `cmd_cnt=1`; `clr_cmd_rdy` -> `cmd_rdy` 0 next cycle.
- `BYTES=3`, `DEPTH=4`: five commands 0x010203..0x0D0E0F with no pops -> `cmd_cnt=4`, `overflow=1`; pops return 0x010203, 0x040506, 0x070809, 0x0A0B0C in order; the fifth command is lost; the pointers wrap cleanly on the next four pushes.
- Full FIFO, final byte accepted in the same cycle as `clr_cmd_rdy` -> `cmd_cnt` stays 4, `overflow` stays 0, and the new command is read out last.
- `TIMEOUT=10`:
  - Byte 0x11, 15 idle cycles -> `timeout_err` pulses once in the 11th cycle after the byte.
  - Then bytes 0x22, 0x33 -> `cmd=0x2233`.
  - Repeat with the second byte exactly 10 cycles after the first -> no `timeout_err` and `cmd=0x1122`.
- Assert `rst` after the first byte of a command with 2 commands queued -> `cmd_cnt=0`, `cmd_rdy=0`, `overflow=0`; the next two bytes 0xBE, 0xEF yield `cmd=0xBEEF`.
- `BYTES=1`: 8 bytes on consecutive cycles with `DEPTH=16` -> `rx_clr_rdy` high each cycle, `cmd_cnt=8`, and the bytes read out in order.

Source files
------------

// File: rtl/uart_cmd_framer.sv
// Command framer: packs BYTES received UART bytes (MSB first) into one command
// word and queues completed commands in a DEPTH-entry FIFO.
module uart_cmd_framer #(
    parameter int unsigned BYTES   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_rdy,
    input  logic [7:0]               rx_data,
    output logic                     rx_clr_rdy,
    input  logic                     clr_cmd_rdy,
    output logic                     cmd_rdy,
    output logic [8*BYTES-1:0]       cmd,
    output logic [$clog2(DEPTH):0]   cmd_cnt,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int unsigned W  = 8 * BYTES;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] BLAST = BW'(BYTES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t         state, state_nx;
    logic [BW-1:0]  bcnt, bcnt_nx;
    logic [TW-1:0]  icnt, icnt_nx;
    logic           tmo_nx;
    logic           accept;
    logic           push;

    logic [W-1:0]   asm_q;
    logic [W-1:0]   word;

    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [AW:0]    count;
    logic           full, pop_ok, push_ok, drop;

    assign rx_clr_rdy = rx_rdy & ~rst;
    assign accept     = rx_clr_rdy;

    // Older bytes simply fall off the top of the truncated shift, so the
    // assembly register never needs clearing between commands.
    assign word = W'({asm_q, rx_data});

    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        icnt_nx  = icnt;
        tmo_nx   = 1'b0;
        push     = 1'b0;
        if (accept) begin
            icnt_nx = '0;
            if (bcnt == BLAST) begin
                push     = 1'b1;
                bcnt_nx  = '0;
                state_nx = IDLE;
            end else begin
                bcnt_nx  = bcnt + 1'b1;
                state_nx = COLLECT;
            end
        end else if (state == COLLECT) begin
            // icnt == TLAST here means this idle cycle brings the count to TIMEOUT.
            if ((TIMEOUT > 0) && (icnt == TLAST)) begin
                tmo_nx   = 1'b1;
                bcnt_nx  = '0;
                icnt_nx  = '0;
                state_nx = IDLE;
            end else if (icnt != TMAX) begin
                icnt_nx = icnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bcnt        <= '0;
            icnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            bcnt        <= bcnt_nx;
            icnt        <= icnt_nx;
            timeout_err <= tmo_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
        end else if (accept) begin
            asm_q <= word;
        end
    end

    assign full    = (count == FULL);
    assign pop_ok  = clr_cmd_rdy && (count != '0);
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign cmd     = mem[rptr];
    assign cmd_rdy = (count != '0);
    assign cmd_cnt = count;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Four framer configurations share one input stream; each is checked every
// cycle against a byte/queue level model plus directed constant checks.
module tb_uart_cmd_framer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       clr_cmd_rdy = 1'b0;

    logic        clr_o  [N];
    logic        rdy_o  [N];
    logic        ovf_o  [N];
    logic        tmo_o  [N];
    logic [63:0] cmd_o  [N];
    logic [7:0]  cnt_o  [N];

    logic [15:0] cmd0, cmd1;
    logic [7:0]  cmd2;
    logic [23:0] cmd3;
    logic [2:0]  cnt0, cnt1, cnt3;
    logic [4:0]  cnt2;

    always #5 clk = ~clk;

    uart_cmd_framer #(.BYTES(2), .DEPTH(4), .TIMEOUT(0)) u0 (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr_rdy(clr_o[0]),
        .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(rdy_o[0]), .cmd(cmd0), .cmd_cnt(cnt0),
        .overflow(ovf_o[0]), .timeout_err(tmo_o[0]));
    uart_cmd_framer #(.BYTES(2), .DEPTH(4), .TIMEOUT(10)) u1 (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr_rdy(clr_o[1]),
        .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(rdy_o[1]), .cmd(cmd1), .cmd_cnt(cnt1),
        .overflow(ovf_o[1]), .timeout_err(tmo_o[1]));
    uart_cmd_framer #(.BYTES(1), .DEPTH(16), .TIMEOUT(0)) u2 (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr_rdy(clr_o[2]),
        .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(rdy_o[2]), .cmd(cmd2), .cmd_cnt(cnt2),
        .overflow(ovf_o[2]), .timeout_err(tmo_o[2]));
    uart_cmd_framer #(.BYTES(3), .DEPTH(4), .TIMEOUT(0)) u3 (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr_rdy(clr_o[3]),
        .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(rdy_o[3]), .cmd(cmd3), .cmd_cnt(cnt3),
        .overflow(ovf_o[3]), .timeout_err(tmo_o[3]));

    assign cmd_o[0] = 64'(cmd0);
    assign cmd_o[1] = 64'(cmd1);
    assign cmd_o[2] = 64'(cmd2);
    assign cmd_o[3] = 64'(cmd3);
    assign cnt_o[0] = 8'(cnt0);
    assign cnt_o[1] = 8'(cnt1);
    assign cnt_o[2] = 8'(cnt2);
    assign cnt_o[3] = 8'(cnt3);

    function automatic int p_bytes(int i);
        case (i)
            2:       return 1;
            3:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int p_depth(int i);
        return (i == 2) ? 16 : 4;
    endfunction

    function automatic int p_tmo(int i);
        return (i == 1) ? 10 : 0;
    endfunction

    // Reference model: bytes held so far, idle cycles since last byte, command queue.
    int          held_n [N];
    logic [63:0] held_v [N];
    int          idle   [N];
    logic [63:0] q      [N][$];
    bit          ovf_m  [N];
    bit          tmo_m  [N];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            tmo_m[i] = 1'b0;
            if (rst) begin
                held_n[i] = 0;
                held_v[i] = '0;
                idle[i]   = 0;
                q[i].delete();
                ovf_m[i]  = 1'b0;
            end else begin
                bit          do_pop;
                bit          do_push;
                logic [63:0] w;
                do_pop  = clr_cmd_rdy && (q[i].size() > 0);
                do_push = 1'b0;
                w       = '0;
                if (rx_rdy) begin
                    held_v[i] = (held_v[i] << 8) | 64'(rx_data);
                    held_n[i]++;
                    idle[i] = 0;
                    if (held_n[i] == p_bytes(i)) begin
                        w         = held_v[i];
                        do_push   = 1'b1;
                        held_n[i] = 0;
                        held_v[i] = '0;
                    end
                end else if (held_n[i] > 0) begin
                    idle[i]++;
                    if (p_tmo(i) > 0 && idle[i] == p_tmo(i)) begin
                        held_n[i] = 0;
                        held_v[i] = '0;
                        idle[i]   = 0;
                        tmo_m[i]  = 1'b1;
                    end
                end
                if (do_pop) begin
                    void'(q[i].pop_front());
                end
                if (do_push) begin
                    if (q[i].size() < p_depth(i)) q[i].push_back(w);
                    else ovf_m[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d.cmd_rdy", i), 64'(rdy_o[i]), 64'(q[i].size() > 0));
            check($sformatf("u%0d.cmd_cnt", i), 64'(cnt_o[i]), 64'(q[i].size()));
            check($sformatf("u%0d.overflow", i), 64'(ovf_o[i]), 64'(ovf_m[i]));
            check($sformatf("u%0d.timeout_err", i), 64'(tmo_o[i]), 64'(tmo_m[i]));
            if (q[i].size() > 0) begin
                check($sformatf("u%0d.cmd", i), cmd_o[i], q[i][0]);
            end
        end
    endtask

    task automatic tick(input bit r, input logic [7:0] d, input bit c, input bit rs);
        @(negedge clk);
        rx_rdy      = r;
        rx_data     = d;
        clr_cmd_rdy = c;
        rst         = rs;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d.rx_clr_rdy", i), 64'(clr_o[i]), 64'(r & ~rs));
        end
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int          pulses;
        int          seen;
        bit          gap_mode;
        logic [63:0] exp;

        do_reset();
        check("rst.cnt", 64'(cnt_o[0]), 64'd0);
        check("rst.rdy", 64'(rdy_o[0]), 64'd0);

        // Default two-byte command and pop.
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        tick(1'b1, 8'h3C, 1'b0, 1'b0);
        check("def.cmd", cmd_o[0], 64'hA53C);
        check("def.rdy", 64'(rdy_o[0]), 64'd1);
        check("def.cnt", 64'(cnt_o[0]), 64'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("def.rdy_after_pop", 64'(rdy_o[0]), 64'd0);

        // Three-byte overflow, ordered readout, then pointer wrap.
        do_reset();
        for (int b = 1; b <= 15; b++) tick(1'b1, 8'(b), 1'b0, 1'b0);
        check("b3.cnt", 64'(cnt_o[3]), 64'd4);
        check("b3.ovf", 64'(ovf_o[3]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            exp = (64'(3 * k + 1) << 16) | (64'(3 * k + 2) << 8) | 64'(3 * k + 3);
            check("b3.pop", cmd_o[3], exp);
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("b3.empty", 64'(cnt_o[3]), 64'd0);
        for (int b = 0; b < 12; b++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 8'h00, 1'b1, 1'b0);

        // Full FIFO, final byte together with a pop.
        do_reset();
        for (int b = 0; b < 12; b++) tick(1'b1, 8'(8'h20 + b), 1'b0, 1'b0);
        tick(1'b1, 8'hA0, 1'b0, 1'b0);
        tick(1'b1, 8'hA1, 1'b0, 1'b0);
        tick(1'b1, 8'hA2, 1'b1, 1'b0);
        check("fp.cnt", 64'(cnt_o[3]), 64'd4);
        check("fp.ovf", 64'(ovf_o[3]), 64'd0);
        for (int k = 0; k < 3; k++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("fp.last", cmd_o[3], 64'hA0A1A2);
        tick(1'b0, 8'h00, 1'b1, 1'b0);

        // Timeout: lone byte expires, then a fresh command frames correctly.
        do_reset();
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        pulses = 0;
        seen   = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (tmo_o[1]) begin
                pulses++;
                seen = k + 1;
            end
        end
        check("tmo.pulses", 64'(pulses), 64'd1);
        check("tmo.cycle", 64'(seen), 64'd11);
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        tick(1'b1, 8'h33, 1'b0, 1'b0);
        check("tmo.cmd", cmd_o[1], 64'h2233);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (tmo_o[1]) pulses++;
        end
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        if (tmo_o[1]) pulses++;
        check("edge.cmd", cmd_o[1], 64'h1122);
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (tmo_o[1]) pulses++;
        end
        check("edge.pulses", 64'(pulses), 64'd0);

        // Reset mid-command with commands queued.
        do_reset();
        for (int b = 1; b <= 5; b++) tick(1'b1, 8'(b), 1'b0, 1'b0);
        check("mid.cnt_before", 64'(cnt_o[0]), 64'd2);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("mid.cnt", 64'(cnt_o[0]), 64'd0);
        check("mid.rdy", 64'(rdy_o[0]), 64'd0);
        check("mid.ovf", 64'(ovf_o[0]), 64'd0);
        tick(1'b1, 8'hBE, 1'b0, 1'b0);
        tick(1'b1, 8'hEF, 1'b0, 1'b0);
        check("mid.cmd", cmd_o[0], 64'hBEEF);

        // Single-byte commands at full rate.
        do_reset();
        for (int b = 0; b < 8; b++) tick(1'b1, 8'(8'h40 + b), 1'b0, 1'b0);
        check("b1.cnt", 64'(cnt_o[2]), 64'd8);
        for (int b = 0; b < 8; b++) begin
            check("b1.order", cmd_o[2], 64'(8'h40 + b));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Random traffic with occasional long gaps and resets.
        do_reset();
        gap_mode = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) gap_mode = ~gap_mode;
            tick(($urandom_range(0, 99) < (gap_mode ? 4 : 60)),
                 8'($urandom),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 499) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
